design_feeder: RTL and testbench

Buffered producer stage sitting directly upstream of the `design` block. It accepts 32-bit words over a valid/ready handshake and presents them to `design` as a strobe (`out_valid` → `i0`) plus word (`out_data` → `i1`). It consumes `design`'s `o` as the per-word acknowledge (`out_ack`). A DEPTH-entry circular buffer decouples the two sides.

---
 rtl/design_feeder.sv | 101 ++++++++++
 tb/tb_design_feeder.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/design_feeder.sv
// design_feeder
//   Buffered producer stage in front of the `design` block. Words arrive on a
//   valid/ready handshake and are held in a DEPTH-entry circular buffer. The
//   head word is presented as a strobe plus data, and `design`'s `o` returns
//   as the per-word acknowledge.
//
// Ports
//   clk          : single clock, rising edge
//   rst          : synchronous active-high reset
//   in_valid     : upstream word available
//   in_data      : upstream word
//   in_ready     : buffer can accept (registered)
//   out_valid    : head word presented (-> design.i0)
//   out_data     : head word, zero when out_valid=0 (-> design.i1)
//   out_ack      : head word consumed (<- design.o)
//   count        : current occupancy (registered)
//   almost_full  : count >= AF_LEVEL (registered)
//   err_spurious : sticky flag, out_ack seen while out_valid=0
module design_feeder #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned AF_LEVEL = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_data,
    input  logic                       out_ack,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       almost_full,
    output logic                       err_spurious
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    logic             push;
    logic             pop;
    logic [CW-1:0]    count_next;

    // Full/empty come from the occupancy counter only; pointer equality
    // is ambiguous between the two.
    assign out_valid = (count != '0);
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

    // in_ready is a register, so a pop while full cannot admit a push in
    // the same cycle and out_ack has no combinational path to in_ready.
    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ack;

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            in_ready     <= 1'b0;
            almost_full  <= 1'b0;
            err_spurious <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
            end
            count       <= count_next;
            in_ready    <= (count_next < DEPTH_C);
            almost_full <= (count_next >= AF_C);
            if (out_ack && !out_valid) begin
                err_spurious <= 1'b1;
            end
        end
    end

    // Storage is not reset; stale entries are unreachable once count is 0.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

endmodule

// File: tb/tb_design_feeder.sv
module tb_design_feeder;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ack;
    logic [2:0]  count;
    logic        almost_full;
    logic        err_spurious;

    int n_checks = 0;
    int n_fail   = 0;

    design_feeder #(.WIDTH(32), .DEPTH(4), .AF_LEVEL(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_ack      (out_ack),
        .count        (count),
        .almost_full  (almost_full),
        .err_spurious (err_spurious)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        out_ack  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (out_valid !== 1'b0 || out_data !== 32'h0 || count !== 3'd0 || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_hold[%0d]: got v=%b d=%h c=%0d rdy=%b, want v=0 d=0 c=0 rdy=0",
                         i, out_valid, out_data, count, in_ready);
            end
        end
        n_checks++;
        if (almost_full !== 1'b0 || err_spurious !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got af=%b err=%b, want 0 0", almost_full, err_spurious);
        end
        rst = 1'b0;
        tick();
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: got %b, want 1", in_ready);
        end
    endtask

    task automatic test_single_word();
        in_valid = 1'b1;
        in_data  = 32'hDEADBEEF;
        tick();
        in_valid = 1'b0;
        in_data  = '0;
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 32'hDEADBEEF || count !== 3'd1) begin
            n_fail++;
            $display("FAIL single_latency: got v=%b d=%h c=%0d, want v=1 d=deadbeef c=1",
                     out_valid, out_data, count);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== 32'hDEADBEEF) begin
                n_fail++;
                $display("FAIL single_hold[%0d]: got v=%b d=%h, want v=1 d=deadbeef", i, out_valid, out_data);
            end
        end
        out_ack = 1'b1;
        tick();
        out_ack = 1'b0;
        n_checks++;
        if (count !== 3'd0 || out_valid !== 1'b0 || out_data !== 32'h0) begin
            n_fail++;
            $display("FAIL single_ack: got c=%0d v=%b d=%h, want c=0 v=0 d=0", count, out_valid, out_data);
        end
    endtask

    task automatic test_fill_full();
        logic [2:0] exp_c;
        for (int k = 1; k <= 5; k++) begin
            in_valid = 1'b1;
            in_data  = 32'(k);
            tick();
            exp_c = (k > 4) ? 3'd4 : 3'(k);
            n_checks++;
            if (count !== exp_c || almost_full !== (k >= 3) || in_ready !== (k < 4)) begin
                n_fail++;
                $display("FAIL fill_step[%0d]: got c=%0d af=%b rdy=%b, want c=%0d af=%b rdy=%b",
                         k, count, almost_full, in_ready, exp_c, (k >= 3), (k < 4));
            end
        end
        in_valid = 1'b0;
        in_data  = '0;
        out_ack  = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== 32'(k)) begin
                n_fail++;
                $display("FAIL fill_drain[%0d]: got v=%b d=%h, want v=1 d=%h", k, out_valid, out_data, 32'(k));
            end
            tick();
        end
        out_ack = 1'b0;
        n_checks++;
        if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL fill_drained: got c=%0d v=%b rdy=%b, want c=0 v=0 rdy=1", count, out_valid, in_ready);
        end
    endtask

    task automatic test_wrap_stream();
        for (int c = 0; c <= 10; c++) begin
            in_valid = (c < 10);
            in_data  = (c < 10) ? 32'(c) : 32'h0;
            out_ack  = (c >= 1);
            if (c >= 1) begin
                n_checks++;
                if (out_valid !== 1'b1 || out_data !== 32'(c - 1)) begin
                    n_fail++;
                    $display("FAIL stream_order[%0d]: got v=%b d=%h, want v=1 d=%h",
                             c, out_valid, out_data, 32'(c - 1));
                end
            end
            tick();
            n_checks++;
            if (count > 3'd1) begin
                n_fail++;
                $display("FAIL stream_count[%0d]: got %0d, want <=1", c, count);
            end
        end
        in_valid = 1'b0;
        out_ack  = 1'b0;
        n_checks++;
        if (count !== 3'd0 || out_valid !== 1'b0 || err_spurious !== 1'b0) begin
            n_fail++;
            $display("FAIL stream_end: got c=%0d v=%b err=%b, want c=0 v=0 err=0", count, out_valid, err_spurious);
        end
    endtask

    task automatic test_back_to_back();
        in_valid = 1'b1;
        in_data  = 32'hA0;
        tick();
        in_data  = 32'hA1;
        tick();
        n_checks++;
        if (count !== 3'd2 || out_data !== 32'hA0) begin
            n_fail++;
            $display("FAIL b2b_prefill: got c=%0d d=%h, want c=2 d=a0", count, out_data);
        end
        out_ack = 1'b1;
        in_data = 32'hA2;
        tick();
        n_checks++;
        if (count !== 3'd2 || out_data !== 32'hA1) begin
            n_fail++;
            $display("FAIL b2b_first: got c=%0d d=%h, want c=2 d=a1", count, out_data);
        end
        in_data = 32'hA3;
        tick();
        n_checks++;
        if (count !== 3'd2 || out_data !== 32'hA2) begin
            n_fail++;
            $display("FAIL b2b_second: got c=%0d d=%h, want c=2 d=a2", count, out_data);
        end
        in_valid = 1'b0;
        in_data  = '0;
        tick();
        n_checks++;
        if (count !== 3'd1 || out_data !== 32'hA3) begin
            n_fail++;
            $display("FAIL b2b_drain: got c=%0d d=%h, want c=1 d=a3", count, out_data);
        end
        tick();
        out_ack = 1'b0;
        n_checks++;
        if (count !== 3'd0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_empty: got c=%0d v=%b, want c=0 v=0", count, out_valid);
        end
    endtask

    task automatic test_spurious_and_reset();
        out_ack = 1'b1;
        tick();
        out_ack = 1'b0;
        n_checks++;
        if (err_spurious !== 1'b1 || count !== 3'd0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL spurious: got err=%b c=%0d v=%b, want err=1 c=0 v=0", err_spurious, count, out_valid);
        end
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_data  = 32'h100 + 32'(k);
            tick();
        end
        in_valid = 1'b0;
        in_data  = '0;
        n_checks++;
        if (count !== 3'd3 || err_spurious !== 1'b1 || out_data !== 32'h100) begin
            n_fail++;
            $display("FAIL spurious_sticky: got c=%0d err=%b d=%h, want c=3 err=1 d=100",
                     count, err_spurious, out_data);
        end
        rst = 1'b1;
        tick();
        n_checks++;
        if (count !== 3'd0 || out_valid !== 1'b0 || out_data !== 32'h0 || err_spurious !== 1'b0
            || in_ready !== 1'b0 || almost_full !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset: got c=%0d v=%b d=%h err=%b rdy=%b af=%b, want 0 0 0 0 0 0",
                     count, out_valid, out_data, err_spurious, in_ready, almost_full);
        end
        rst = 1'b0;
        tick();
        n_checks++;
        if (in_ready !== 1'b1 || count !== 3'd0) begin
            n_fail++;
            $display("FAIL midreset_release: got rdy=%b c=%0d, want rdy=1 c=0", in_ready, count);
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_fill_full();
        test_wrap_stream();
        test_back_to_back();
        test_spurious_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
